// File: rtl/muldiv_pkg.sv
// Shared definitions between the DIV issue controller and the DIV unit.
package muldiv_pkg;

    localparam int unsigned OPC_W            = 2;
    localparam int unsigned OPC_UNSIGNED_BIT = 0;
    localparam int unsigned OPC_REM_BIT      = 1;
    localparam int unsigned ST_W             = 3;

    typedef enum logic [OPC_W-1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } div_ctrl_state_e;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// EX <-> controller <-> DIV signal bundle.
//  master : the issue controller (drives ex_ready/ex_result and the DIV request)
//  slave  : the environment (EX stage plus DIV unit)
interface div_issue_ctrl_if
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic             ex_valid;
    logic             ex_ready;
    logic             ex_flush;
    logic [OPC_W-1:0] ex_opcode;
    logic [XLEN-1:0]  ex_op1;
    logic [XLEN-1:0]  ex_op2;
    logic [XLEN-1:0]  ex_result;
    logic             div_in_valid;
    logic             div_in_ready;
    logic [OPC_W-1:0] div_opcode;
    logic [XLEN-1:0]  div_op1;
    logic [XLEN-1:0]  div_op2;
    logic             div_out_valid;
    logic [XLEN-1:0]  div_result;

    modport master (
        input  ex_valid, ex_flush, ex_opcode, ex_op1, ex_op2,
               div_in_ready, div_out_valid, div_result,
        output ex_ready, ex_result, div_in_valid, div_opcode, div_op1, div_op2
    );

    modport slave (
        output ex_valid, ex_flush, ex_opcode, ex_op1, ex_op2,
               div_in_ready, div_out_valid, div_result,
        input  ex_ready, ex_result, div_in_valid, div_opcode, div_op1, div_op2
    );
endinterface

// File: rtl/div_special_case.sv
// Resolves RISC-V divide-by-zero and signed-overflow results without the DIV unit.
//  opcode/op1/op2 in -> is_special (case detected), special_result (architectural result)
module div_special_case
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [XLEN-1:0]  op1,
    input  logic [XLEN-1:0]  op2,
    output logic             is_special,
    output logic [XLEN-1:0]  special_result
);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    always_comb begin
        is_special     = 1'b0;
        special_result = '0;
        if (op2 == '0) begin
            is_special     = 1'b1;
            special_result = opcode[OPC_REM_BIT] ? op1 : '1;
        end else if (!opcode[OPC_UNSIGNED_BIT] && (op1 == INT_MIN) && (op2 == '1)) begin
            is_special     = 1'b1;
            special_result = opcode[OPC_REM_BIT] ? '0 : op1;
        end
    end
endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage requester for the DIV unit: stalls EX while a div/rem is outstanding,
// resolves special cases locally and optionally replays the last DIV result.
//  clk, rst_b : clock, synchronous active-low reset
//  bus        : EX request/response and DIV in/out handshake (master side)
module div_issue_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          CACHE_EN = 1'b1
) (
    input logic              clk,
    input logic              rst_b,
    div_issue_ctrl_if.master bus
);
    localparam logic [ST_W-1:0] S_IDLE  = ST_IDLE;
    localparam logic [ST_W-1:0] S_ISSUE = ST_ISSUE;
    localparam logic [ST_W-1:0] S_WAIT  = ST_WAIT;
    localparam logic [ST_W-1:0] S_RESP  = ST_RESP;
    localparam logic [ST_W-1:0] S_DRAIN = ST_DRAIN;

    logic [ST_W-1:0]  state_q, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic [XLEN-1:0]  op1_q, op1_d, op2_q, op2_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic             ex_ready_q, ex_ready_d;
    logic             div_in_valid_q, div_in_valid_d;
    logic             cache_vld_q, cache_vld_d;
    logic [OPC_W-1:0] cache_opc_q, cache_opc_d;
    logic [XLEN-1:0]  cache_op1_q, cache_op1_d, cache_op2_q, cache_op2_d;
    logic [XLEN-1:0]  cache_res_q, cache_res_d;

    logic             is_special;
    logic [XLEN-1:0]  special_result;
    logic             cache_hit_c;

    div_special_case #(.XLEN(XLEN)) u_special (
        .opcode         (bus.ex_opcode),
        .op1            (bus.ex_op1),
        .op2            (bus.ex_op2),
        .is_special     (is_special),
        .special_result (special_result)
    );

    assign cache_hit_c = CACHE_EN && cache_vld_q && (cache_opc_q == bus.ex_opcode) &&
                         (cache_op1_q == bus.ex_op1) && (cache_op2_q == bus.ex_op2);

    // Next-state / next-output logic
    always_comb begin
        state_d        = state_q;
        opc_d          = opc_q;
        op1_d          = op1_q;
        op2_d          = op2_q;
        res_d          = res_q;
        ex_ready_d     = 1'b0;
        div_in_valid_d = 1'b0;
        cache_vld_d    = cache_vld_q;
        cache_opc_d    = cache_opc_q;
        cache_op1_d    = cache_op1_q;
        cache_op2_d    = cache_op2_q;
        cache_res_d    = cache_res_q;

        case (state_q)
            S_IDLE: begin
                if (bus.ex_valid && !bus.ex_flush) begin
                    opc_d = bus.ex_opcode;
                    op1_d = bus.ex_op1;
                    op2_d = bus.ex_op2;
                    if (is_special) begin
                        res_d      = special_result;
                        ex_ready_d = 1'b1;
                        state_d    = S_RESP;
                    end else if (cache_hit_c) begin
                        res_d      = cache_res_q;
                        ex_ready_d = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        div_in_valid_d = 1'b1;
                        state_d        = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (bus.ex_flush) begin
                    // An acceptance in the flush cycle still leaves a result to swallow
                    state_d = (bus.div_in_ready && !bus.div_out_valid) ? S_DRAIN : S_IDLE;
                end else if (bus.div_in_ready) begin
                    state_d = S_WAIT;
                end else begin
                    div_in_valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                // A result arriving in the flush cycle is dropped here instead of drained
                if (bus.ex_flush) begin
                    state_d = bus.div_out_valid ? S_IDLE : S_DRAIN;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (bus.div_out_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // DIV result capture, shared by ISSUE (same-cycle response) and WAIT
        if (!bus.ex_flush && bus.div_out_valid &&
            ((state_q == S_WAIT) || ((state_q == S_ISSUE) && bus.div_in_ready))) begin
            res_d      = bus.div_result;
            ex_ready_d = 1'b1;
            state_d    = S_RESP;
            if (CACHE_EN) begin
                cache_vld_d = 1'b1;
                cache_opc_d = opc_q;
                cache_op1_d = op1_q;
                cache_op2_d = op2_q;
                cache_res_d = bus.div_result;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q        <= S_IDLE;
            opc_q          <= '0;
            op1_q          <= '0;
            op2_q          <= '0;
            res_q          <= '0;
            ex_ready_q     <= 1'b0;
            div_in_valid_q <= 1'b0;
            cache_vld_q    <= 1'b0;
            cache_opc_q    <= '0;
            cache_op1_q    <= '0;
            cache_op2_q    <= '0;
            cache_res_q    <= '0;
        end else begin
            state_q        <= state_d;
            opc_q          <= opc_d;
            op1_q          <= op1_d;
            op2_q          <= op2_d;
            res_q          <= res_d;
            ex_ready_q     <= ex_ready_d;
            div_in_valid_q <= div_in_valid_d;
            cache_vld_q    <= cache_vld_d;
            cache_opc_q    <= cache_opc_d;
            cache_op1_q    <= cache_op1_d;
            cache_op2_q    <= cache_op2_d;
            cache_res_q    <= cache_res_d;
        end
    end

    assign bus.ex_ready     = ex_ready_q;
    assign bus.ex_result    = res_q;
    assign bus.div_in_valid = div_in_valid_q;
    assign bus.div_opcode   = opc_q;
    assign bus.div_op1      = op1_q;
    assign bus.div_op2      = op2_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a configurable-latency DIV unit model.
module tb_div_issue_ctrl;
    logic clk;
    logic rst_b;

    div_issue_ctrl_if #(.XLEN(32)) bus ();

    div_issue_ctrl #(.XLEN(32), .CACHE_EN(1'b1)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // DIV unit reference arithmetic (never called with special operands)
    function automatic logic [31:0] div_ref(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (b == 32'd0) return 32'd0;
        case (o)
            2'b00:   r = 32'($signed(a) / $signed(b));
            2'b01:   r = a / b;
            2'b10:   r = 32'($signed(a) % $signed(b));
            default: r = a % b;
        endcase
        return r;
    endfunction

    // DIV unit model: in_ready after acc_delay stall cycles, result lat cycles after acceptance
    int          acc_delay = 0;
    int          lat       = 0;
    int          acc_cnt;
    int          lat_cnt;
    logic        busy;
    logic [31:0] pend_res;

    always_comb begin
        bus.div_in_ready  = bus.div_in_valid && (acc_cnt >= acc_delay) && !busy;
        bus.div_out_valid = (busy && (lat_cnt == 0)) || (bus.div_in_ready && (lat == 0));
        bus.div_result    = busy ? pend_res : div_ref(bus.div_opcode, bus.div_op1, bus.div_op2);
    end

    always @(posedge clk) begin
        if (!rst_b) begin
            busy    <= 1'b0;
            acc_cnt <= 0;
            lat_cnt <= 0;
        end else if (bus.div_in_valid && bus.div_in_ready) begin
            acc_cnt <= 0;
            if (lat > 0) begin
                busy     <= 1'b1;
                lat_cnt  <= lat - 1;
                pend_res <= div_ref(bus.div_opcode, bus.div_op1, bus.div_op2);
            end
        end else begin
            acc_cnt <= bus.div_in_valid ? acc_cnt + 1 : 0;
            if (busy) begin
                if (lat_cnt == 0) busy <= 1'b0;
                else              lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // Handshake monitor: request-valid cycles, acceptances, operand stability while stalled
    int          ivc  = 0;
    int          accn = 0;
    int          viol = 0;
    logic        p_v  = 1'b0;
    logic        p_r  = 1'b0;
    logic [1:0]  p_o;
    logic [31:0] p_1, p_2;

    always @(negedge clk) begin
        if (bus.div_in_valid) ivc++;
        if (bus.div_in_valid && bus.div_in_ready) accn++;
        if (p_v && !p_r && bus.div_in_valid &&
            ((bus.div_opcode !== p_o) || (bus.div_op1 !== p_1) || (bus.div_op2 !== p_2)))
            viol++;
        p_v = bus.div_in_valid;
        p_r = bus.div_in_ready;
        p_o = bus.div_opcode;
        p_1 = bus.div_op1;
        p_2 = bus.div_op2;
    end

    // One EX request: returns cycles to ex_ready, result, valid-cycles and acceptances seen
    task automatic do_req(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic [31:0] res, output int nv, output int na);
        int v0, a0;
        v0  = ivc;
        a0  = accn;
        res = 32'hDEAD_BEEF;
        bus.ex_opcode = o;
        bus.ex_op1    = a;
        bus.ex_op2    = b;
        bus.ex_valid  = 1'b1;
        cyc = 0;
        while (cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.ex_ready) begin
                res = bus.ex_result;
                break;
            end
        end
        bus.ex_valid = 1'b0;
        @(posedge clk); #1;
        check("ready_one_cycle", 32'(bus.ex_ready), 32'd0);
        nv = ivc - v0;
        na = accn - a0;
    endtask

    typedef struct {
        logic [1:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        int          acc;
        int          lt;
        logic [31:0] exp_res;
        int          exp_lat;
        int          exp_acc;
    } vec_t;

    vec_t        vecs [11];
    int          cyc, nv, na;
    logic [31:0] res;
    string       tag;

    initial begin
        vecs[0]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,         0, 0, 32'hFFFF_FFFD, 2,  1};
        vecs[1]  = '{2'b11, 32'd7,         32'd0,         0, 0, 32'd7,         1,  0};
        vecs[2]  = '{2'b01, 32'd5,         32'd0,         0, 0, 32'hFFFF_FFFF, 1,  0};
        vecs[3]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h8000_0000, 1,  0};
        vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'd0,         1,  0};
        vecs[5]  = '{2'b01, 32'd100,       32'd7,         3, 5, 32'd14,        10, 1};
        vecs[6]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         0, 2, 32'hFFFF_FFFF, 4,  1};
        vecs[7]  = '{2'b00, 32'd0,         32'd0,         0, 0, 32'hFFFF_FFFF, 1,  0};
        vecs[8]  = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'd0,         3,  1};
        vecs[9]  = '{2'b11, 32'd100,       32'd7,         1, 0, 32'd2,         3,  1};
        vecs[10] = '{2'b11, 32'd100,       32'd7,         1, 0, 32'd2,         1,  0};

        bus.ex_valid  = 1'b0;
        bus.ex_flush  = 1'b0;
        bus.ex_opcode = 2'b00;
        bus.ex_op1    = 32'd0;
        bus.ex_op2    = 32'd0;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ex_ready",     32'(bus.ex_ready),     32'd0);
        check("rst_ex_result",    bus.ex_result,         32'd0);
        check("rst_div_in_valid", 32'(bus.div_in_valid), 32'd0);
        check("rst_div_op1",      bus.div_op1,           32'd0);
        rst_b = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            acc_delay = vecs[i].acc;
            lat       = vecs[i].lt;
            do_req(vecs[i].opc, vecs[i].a, vecs[i].b, cyc, res, nv, na);
            tag = $sformatf("v%0d", i);
            check({tag, "_result"},  res,     vecs[i].exp_res);
            check({tag, "_latency"}, 32'(cyc), 32'(vecs[i].exp_lat));
            check({tag, "_accepts"}, 32'(na),  32'(vecs[i].exp_acc));
            check({tag, "_vcycles"}, 32'(nv),  32'(vecs[i].exp_acc * (1 + vecs[i].acc)));
        end

        // Flush together with ex_valid in IDLE: nothing starts
        bus.ex_opcode = 2'b00; bus.ex_op1 = 32'd40; bus.ex_op2 = 32'd3;
        bus.ex_valid = 1'b1; bus.ex_flush = 1'b1;
        @(posedge clk); #1;
        check("idle_flush_valid", 32'(bus.div_in_valid), 32'd0);
        check("idle_flush_ready", 32'(bus.ex_ready),     32'd0);
        bus.ex_valid = 1'b0; bus.ex_flush = 1'b0;

        // Flush in ISSUE before acceptance: request withdrawn, DIV never accepts
        acc_delay = 5; lat = 0;
        na = accn;
        bus.ex_valid = 1'b1;
        @(posedge clk); #1;
        check("issue_valid", 32'(bus.div_in_valid), 32'd1);
        bus.ex_valid = 1'b0; bus.ex_flush = 1'b1;
        @(posedge clk); #1;
        bus.ex_flush = 1'b0;
        check("issue_flush_valid", 32'(bus.div_in_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("issue_flush_ready", 32'(bus.ex_ready), 32'd0);
        check("issue_flush_accepts", 32'(accn - na), 32'd0);

        // Flush in WAIT: stale DIV 20/3 drained, then REM 9/4 returns 1
        acc_delay = 0; lat = 4;
        bus.ex_opcode = 2'b00; bus.ex_op1 = 32'd20; bus.ex_op2 = 32'd3;
        bus.ex_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wait_valid_dropped", 32'(bus.div_in_valid), 32'd0);
        bus.ex_valid = 1'b0; bus.ex_flush = 1'b1;
        @(posedge clk); #1;
        bus.ex_flush = 1'b0;
        lat = 0;
        do_req(2'b10, 32'd9, 32'd4, cyc, res, nv, na);
        check("after_drain_result",  res,      32'd1);
        check("after_drain_latency", 32'(cyc), 32'd5);
        do_req(2'b10, 32'd9, 32'd4, cyc, res, nv, na);
        check("hit_result",  res,      32'd1);
        check("hit_latency", 32'(cyc), 32'd1);
        check("hit_accepts", 32'(na),  32'd0);
        do_req(2'b00, 32'd20, 32'd3, cyc, res, nv, na);
        check("drained_not_cached_result",  res,     32'd6);
        check("drained_not_cached_accepts", 32'(na), 32'd1);

        // Reset mid-WAIT clears outputs and the cache
        do_req(2'b01, 32'd50, 32'd5, cyc, res, nv, na);
        check("pre_reset_result", res, 32'd10);
        lat = 6;
        bus.ex_opcode = 2'b00; bus.ex_op1 = 32'd9; bus.ex_op2 = 32'd3;
        bus.ex_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ex_ready",     32'(bus.ex_ready),     32'd0);
        check("mid_rst_ex_result",    bus.ex_result,         32'd0);
        check("mid_rst_div_in_valid", 32'(bus.div_in_valid), 32'd0);
        check("mid_rst_div_opcode",   32'(bus.div_opcode),   32'd0);
        check("mid_rst_div_op1",      bus.div_op1,           32'd0);
        check("mid_rst_div_op2",      bus.div_op2,           32'd0);
        bus.ex_valid = 1'b0;
        rst_b = 1'b1;
        lat = 0;
        @(posedge clk); #1;
        do_req(2'b01, 32'd50, 32'd5, cyc, res, nv, na);
        check("post_rst_result",  res,      32'd10);
        check("post_rst_latency", 32'(cyc), 32'd2);
        check("post_rst_accepts", 32'(na),  32'd1);

        check("operands_stable_while_stalled", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
